esm_config_decoder: RTL and testbench

Single-clock AXI-stream configuration message decoder for the ESM receiver. It parses framed control messages: word0 is the magic number, word1 is the sequence number, word2 is {module_id[31:24], msg_type[23:16], addr[15:0]}, word3 is padding, and words 4..N are payload. It validates each frame and routes the payload to one of NUM_MODULES destinations (dwell controller, channelizer, etc.) as a one-hot-qualified broadcast bus. It also reports framing, sequence and length errors.

---
 rtl/esm_pkg.sv | 28 ++
 rtl/esm_config_decoder.sv | 226 ++++++++++++++++++++++
 tb/tb_esm_config_decoder.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/esm_pkg.sv
// Shared types and constants for the ESM receiver control path: config header layout,
// decoder state encoding and the control-message magic number.
package esm_pkg;

  localparam logic [31:0] esm_control_magic_num  = 32'hE5C0_C0DE;
  localparam int          esm_config_header_words = 4;
  localparam int          esm_config_num_modules  = 4;

  typedef struct packed {
    logic [7:0]  module_id;
    logic [7:0]  msg_type;
    logic [15:0] addr;
  } esm_config_header_t;

  typedef enum logic [2:0] {
    S_MAGIC   = 3'd0,
    S_SEQ     = 3'd1,
    S_HDR     = 3'd2,
    S_PAD     = 3'd3,
    S_PAYLOAD = 3'd4,
    S_DROP    = 3'd5
  } esm_config_state_t;

  function automatic esm_config_header_t esm_config_header_unpack(input logic [31:0] w);
    return esm_config_header_t'(w);
  endfunction

endpackage

// File: rtl/esm_config_decoder.sv
// Decodes framed AXI-stream config messages and routes payload words to one destination module.
// All outputs registered (1 cycle from beat); input is never backpressured once out of reset.
module esm_config_decoder
  import esm_pkg::*;
#(
  parameter int          AXI_DATA_WIDTH    = 32,
  parameter int          NUM_MODULES       = esm_config_num_modules,
  parameter int          MAX_PAYLOAD_WORDS = 64,
  parameter logic [31:0] MAGIC_NUM         = esm_control_magic_num,
  parameter bit          ENABLE_SEQ_CHECK  = 1'b1,
  localparam int         IDX_W = (MAX_PAYLOAD_WORDS > 1) ? $clog2(MAX_PAYLOAD_WORDS) : 1
) (
  input  logic                      S_axis_clk,
  input  logic                      S_axis_resetn,
  input  logic                      S_axis_valid,
  output logic                      S_axis_ready,
  input  logic [AXI_DATA_WIDTH-1:0] S_axis_data,
  input  logic                      S_axis_last,
  output logic [NUM_MODULES-1:0]    Cfg_valid,
  output logic                      Cfg_first,
  output logic                      Cfg_last,
  output logic [AXI_DATA_WIDTH-1:0] Cfg_data,
  output logic [7:0]                Cfg_msg_type,
  output logic [15:0]               Cfg_addr,
  output logic [IDX_W-1:0]          Cfg_word_index,
  output logic                      Magic_error,
  output logic                      Seq_error,
  output logic                      Module_error,
  output logic                      Short_error,
  output logic                      Length_error,
  output logic [31:0]               Msg_count
);

  if (AXI_DATA_WIDTH != 32) begin : g_bad_width
    $error("esm_config_decoder: AXI_DATA_WIDTH must be 32");
  end

  // Payload counter needs one extra code so it can saturate at MAX_PAYLOAD_WORDS.
  localparam int             CNT_W    = $clog2(MAX_PAYLOAD_WORDS + 1);
  localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_PAYLOAD_WORDS);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(MAX_PAYLOAD_WORDS - 1);
  localparam logic [8:0]     NUM_MOD  = 9'(NUM_MODULES);

  esm_config_state_t     state_q, state_d;
  logic [CNT_W-1:0]      idx_q, idx_d;
  logic [7:0]            mod_q, mod_d;
  logic [7:0]            msg_type_q, msg_type_d;
  logic [15:0]           addr_q, addr_d;
  logic                  len_seen_q, len_seen_d;
  logic                  seq_seen_q, seq_seen_d;
  logic [31:0]           last_seq_q, last_seq_d;
  logic                  ready_q;
  logic [NUM_MODULES-1:0] valid_q, valid_d;
  logic                  first_q, first_d;
  logic                  clast_q, clast_d;
  logic [31:0]           data_q, data_d;
  logic [IDX_W-1:0]      widx_q, widx_d;
  logic                  magic_err_q, magic_err_d;
  logic                  seq_err_q, seq_err_d;
  logic                  mod_err_q, mod_err_d;
  logic                  short_err_q, short_err_d;
  logic                  len_err_q, len_err_d;
  logic [31:0]           count_q, count_d;

  logic               beat;
  esm_config_header_t hdr;
  logic               excess;

  assign beat   = S_axis_valid & ready_q;
  assign hdr    = esm_config_header_unpack(S_axis_data);
  assign excess = (idx_q >= MAX_CNT);

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    mod_d       = mod_q;
    msg_type_d  = msg_type_q;
    addr_d      = addr_q;
    len_seen_d  = len_seen_q;
    seq_seen_d  = seq_seen_q;
    last_seq_d  = last_seq_q;
    valid_d     = '0;
    first_d     = 1'b0;
    clast_d     = 1'b0;
    data_d      = data_q;
    widx_d      = widx_q;
    magic_err_d = 1'b0;
    seq_err_d   = 1'b0;
    mod_err_d   = 1'b0;
    short_err_d = 1'b0;
    len_err_d   = 1'b0;
    count_d     = count_q;

    if (beat) begin
      unique case (state_q)
        S_MAGIC: begin
          if (S_axis_data == MAGIC_NUM) begin
            state_d = S_SEQ;
          end else begin
            magic_err_d = 1'b1;
            state_d     = S_axis_last ? S_MAGIC : S_DROP;
          end
        end
        S_SEQ: begin
          // Sequence tracking follows the received value even on a short frame.
          if (S_axis_last) begin
            short_err_d = 1'b1;
            state_d     = S_MAGIC;
          end else begin
            seq_err_d = ENABLE_SEQ_CHECK && seq_seen_q && (S_axis_data != last_seq_q + 32'd1);
            state_d   = S_HDR;
          end
          last_seq_d = S_axis_data;
          seq_seen_d = 1'b1;
        end
        S_HDR: begin
          mod_d      = hdr.module_id;
          msg_type_d = hdr.msg_type;
          addr_d     = hdr.addr;
          if (S_axis_last) begin
            short_err_d = 1'b1;
            state_d     = S_MAGIC;
          end else if ({1'b0, hdr.module_id} >= NUM_MOD) begin
            mod_err_d = 1'b1;
            state_d   = S_DROP;
          end else begin
            state_d = S_PAD;
          end
        end
        S_PAD: begin
          if (S_axis_last) begin
            short_err_d = 1'b1;
            state_d     = S_MAGIC;
          end else begin
            idx_d      = '0;
            len_seen_d = 1'b0;
            state_d    = S_PAYLOAD;
          end
        end
        S_PAYLOAD: begin
          if (!excess) begin
            valid_d = NUM_MODULES'(1) << mod_q;
            first_d = (idx_q == '0);
            clast_d = S_axis_last | (idx_q == LAST_IDX);
            data_d  = S_axis_data;
            widx_d  = idx_q[IDX_W-1:0];
            idx_d   = idx_q + 1'b1;
          end else if (!len_seen_q) begin
            len_err_d  = 1'b1;
            len_seen_d = 1'b1;
          end
          if (S_axis_last) begin
            state_d = S_MAGIC;
            if (!len_seen_q && !excess) count_d = count_q + 32'd1;
          end
        end
        S_DROP: begin
          if (S_axis_last) state_d = S_MAGIC;
        end
        default: state_d = S_MAGIC;
      endcase
    end
  end

  always_ff @(posedge S_axis_clk or negedge S_axis_resetn) begin
    if (!S_axis_resetn) begin
      state_q     <= S_MAGIC;
      idx_q       <= '0;
      mod_q       <= '0;
      msg_type_q  <= '0;
      addr_q      <= '0;
      len_seen_q  <= 1'b0;
      seq_seen_q  <= 1'b0;
      last_seq_q  <= '0;
      ready_q     <= 1'b0;
      valid_q     <= '0;
      first_q     <= 1'b0;
      clast_q     <= 1'b0;
      data_q      <= '0;
      widx_q      <= '0;
      magic_err_q <= 1'b0;
      seq_err_q   <= 1'b0;
      mod_err_q   <= 1'b0;
      short_err_q <= 1'b0;
      len_err_q   <= 1'b0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      mod_q       <= mod_d;
      msg_type_q  <= msg_type_d;
      addr_q      <= addr_d;
      len_seen_q  <= len_seen_d;
      seq_seen_q  <= seq_seen_d;
      last_seq_q  <= last_seq_d;
      ready_q     <= 1'b1;
      valid_q     <= valid_d;
      first_q     <= first_d;
      clast_q     <= clast_d;
      data_q      <= data_d;
      widx_q      <= widx_d;
      magic_err_q <= magic_err_d;
      seq_err_q   <= seq_err_d;
      mod_err_q   <= mod_err_d;
      short_err_q <= short_err_d;
      len_err_q   <= len_err_d;
      count_q     <= count_d;
    end
  end

  assign S_axis_ready   = ready_q;
  assign Cfg_valid      = valid_q;
  assign Cfg_first      = first_q;
  assign Cfg_last       = clast_q;
  assign Cfg_data       = data_q;
  assign Cfg_msg_type   = msg_type_q;
  assign Cfg_addr       = addr_q;
  assign Cfg_word_index = widx_q;
  assign Magic_error    = magic_err_q;
  assign Seq_error      = seq_err_q;
  assign Module_error   = mod_err_q;
  assign Short_error    = short_err_q;
  assign Length_error   = len_err_q;
  assign Msg_count      = count_q;

endmodule

// File: tb/tb_esm_config_decoder.sv
// Randomized frame-level bench for esm_config_decoder; a second instance runs with sequence
// checking disabled and must show identical traffic minus the Seq_error pulses.
module tb_esm_config_decoder;
  import esm_pkg::*;

  localparam int          NM    = 4;
  localparam int          MAXP  = 4;
  localparam int          IW    = 2;
  localparam logic [31:0] MAGIC = esm_control_magic_num;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        in_vld = 1'b0, in_last = 1'b0;
  logic [31:0] in_dat = '0;

  logic          rdy, first, clast, merr, serr, moderr, sherr, lerr;
  logic [NM-1:0] vld;
  logic [31:0]   dat, cnt;
  logic [7:0]    mt;
  logic [15:0]   addr;
  logic [IW-1:0] widx;

  logic          n_rdy, n_first, n_clast, n_merr, n_serr, n_moderr, n_sherr, n_lerr;
  logic [NM-1:0] n_vld;
  logic [31:0]   n_dat, n_cnt;
  logic [7:0]    n_mt;
  logic [15:0]   n_addr;
  logic [IW-1:0] n_widx;

  esm_config_decoder #(.NUM_MODULES(NM), .MAX_PAYLOAD_WORDS(MAXP), .ENABLE_SEQ_CHECK(1'b1)) dut (
    .S_axis_clk(clk), .S_axis_resetn(rst_n), .S_axis_valid(in_vld), .S_axis_ready(rdy),
    .S_axis_data(in_dat), .S_axis_last(in_last), .Cfg_valid(vld), .Cfg_first(first),
    .Cfg_last(clast), .Cfg_data(dat), .Cfg_msg_type(mt), .Cfg_addr(addr),
    .Cfg_word_index(widx), .Magic_error(merr), .Seq_error(serr), .Module_error(moderr),
    .Short_error(sherr), .Length_error(lerr), .Msg_count(cnt));

  esm_config_decoder #(.NUM_MODULES(NM), .MAX_PAYLOAD_WORDS(MAXP), .ENABLE_SEQ_CHECK(1'b0)) dut_noseq (
    .S_axis_clk(clk), .S_axis_resetn(rst_n), .S_axis_valid(in_vld), .S_axis_ready(n_rdy),
    .S_axis_data(in_dat), .S_axis_last(in_last), .Cfg_valid(n_vld), .Cfg_first(n_first),
    .Cfg_last(n_clast), .Cfg_data(n_dat), .Cfg_msg_type(n_mt), .Cfg_addr(n_addr),
    .Cfg_word_index(n_widx), .Magic_error(n_merr), .Seq_error(n_serr), .Module_error(n_moderr),
    .Short_error(n_sherr), .Length_error(n_lerr), .Msg_count(n_cnt));

  typedef struct packed {
    logic [NM-1:0] vld;
    logic          first;
    logic          last;
    logic [31:0]   data;
    logic [IW-1:0] idx;
    logic [7:0]    mt;
    logic [15:0]   addr;
    logic [4:0]    err;   // {magic, seq, module, short, length}
    logic [31:0]   cnt;
  } ev_t;

  localparam logic [4:0] E_MAGIC = 5'b10000, E_SEQ = 5'b01000, E_MOD = 5'b00100,
                         E_SHORT = 5'b00010, E_LEN = 5'b00001;

  ev_t         exp_q[$], exp2_q[$];
  logic [31:0] frame[$];
  int          vectors = 0, miscompares = 0;
  bit          mon_en = 1'b0;

  // Reference state: what the receiver should remember between frames.
  bit          m_seen = 1'b0;
  logic [31:0] m_last_seq = '0;
  logic [31:0] m_count = '0;

  function automatic ev_t act1();
    return '{vld, first, clast, dat, widx, mt, addr, {merr, serr, moderr, sherr, lerr}, cnt};
  endfunction
  function automatic ev_t act2();
    return '{n_vld, n_first, n_clast, n_dat, n_widx, n_mt, n_addr,
             {n_merr, n_serr, n_moderr, n_sherr, n_lerr}, n_cnt};
  endfunction

  task automatic compare(input string nm, input ev_t act, input ev_t exp);
    vectors++;
    if (exp.vld == '0) begin
      act.data = '0; act.idx = '0; act.mt = '0; act.addr = '0;
    end
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    ev_t a;
    if (mon_en) begin
      a = act1();
      if (a.vld != '0 || a.err != '0) begin
        if (exp_q.size() == 0) compare("unexpected_output", a, '0);
        else compare("event", a, exp_q.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    ev_t a;
    if (mon_en) begin
      a = act2();
      if (a.vld != '0 || a.err != '0) begin
        if (exp2_q.size() == 0) compare("noseq_unexpected_output", a, '0);
        else compare("noseq_event", a, exp2_q.pop_front());
      end
    end
  end

  task automatic push_err(input logic [4:0] err);
    ev_t e;
    e = '0; e.err = err; e.cnt = m_count;
    exp_q.push_back(e);
    if (err != E_SEQ) exp2_q.push_back(e);
  endtask

  // Frame-level reference: expected outputs for the first 'sent' beats of 'frame'.
  task automatic model_frame(input int sent);
    int n, p;
    logic [7:0] id;
    ev_t e;
    n = frame.size();
    if (sent < 1) return;
    if (frame[0] != MAGIC) begin push_err(E_MAGIC); return; end
    if (sent < 2) return;
    if (n == 2) begin
      m_seen = 1'b1; m_last_seq = frame[1]; push_err(E_SHORT); return;
    end
    if (m_seen && frame[1] != m_last_seq + 32'd1) push_err(E_SEQ);
    m_seen = 1'b1; m_last_seq = frame[1];
    if (sent < 3) return;
    if (n == 3) begin push_err(E_SHORT); return; end
    id = frame[2][31:24];
    if (int'(id) >= NM) begin push_err(E_MOD); return; end
    if (sent < 4) return;
    if (n == 4) begin push_err(E_SHORT); return; end
    p = n - 4;
    for (int k = 0; k < p && 4 + k < sent; k++) begin
      if (k < MAXP) begin
        e       = '0;
        e.vld   = NM'(1) << id;
        e.first = (k == 0);
        e.last  = (k == p - 1) || (k == MAXP - 1);
        e.data  = frame[4 + k];
        e.idx   = IW'(k);
        e.mt    = frame[2][23:16];
        e.addr  = frame[2][15:0];
        e.cnt   = (k == p - 1) ? m_count + 32'd1 : m_count;
        exp_q.push_back(e);
        exp2_q.push_back(e);
      end else if (k == MAXP) begin
        push_err(E_LEN);
      end
    end
    if (sent >= n && p <= MAXP) m_count = m_count + 32'd1;
  endtask

  task automatic send_word(input logic [31:0] d, input logic l);
    repeat ($urandom_range(0, 2)) @(negedge clk);
    in_vld = 1'b1; in_dat = d; in_last = l;
    @(negedge clk);
    in_vld = 1'b0; in_last = 1'b0;
  endtask

  task automatic send_frame(input int sent);
    model_frame(sent);
    for (int i = 0; i < sent; i++) send_word(frame[i], i == frame.size() - 1);
  endtask

  task automatic mk(input logic [31:0] seq, input logic [31:0] hw, input int p);
    frame.delete();
    frame.push_back(MAGIC); frame.push_back(seq); frame.push_back(hw);
    frame.push_back(32'hDEADBEEF);
    for (int i = 0; i < p; i++) frame.push_back(32'hA + 32'(i));
  endtask

  task automatic gen_random();
    int kind, p, n;
    logic [7:0] id;
    logic [31:0] seq;
    kind = $urandom_range(0, 9);
    id   = 8'($urandom_range(0, NM - 1));
    p    = $urandom_range(1, MAXP);
    seq  = m_last_seq + 32'd1;
    if (kind == 2) id = 8'($urandom_range(NM, 255));
    if (kind == 3) p = $urandom_range(MAXP + 1, MAXP + 3);
    if (kind == 4) seq = m_last_seq + 32'($urandom_range(2, 100));
    frame.delete();
    if (kind == 0) begin
      n = $urandom_range(1, 6);
      frame.push_back(MAGIC ^ ($urandom() | 32'd1));
      for (int i = 1; i < n; i++) frame.push_back($urandom());
    end else begin
      frame.push_back(MAGIC); frame.push_back(seq);
      frame.push_back({id, 8'($urandom()), 16'($urandom())});
      frame.push_back($urandom());
      for (int i = 0; i < p; i++) frame.push_back($urandom());
      if (kind == 1) begin
        n = $urandom_range(2, 4);
        while (frame.size() > n) void'(frame.pop_back());
      end
    end
    send_frame(frame.size());
  endtask

  task automatic drain();
    for (int i = 0; i < 50 && (exp_q.size() != 0 || exp2_q.size() != 0); i++) @(negedge clk);
    check("drain_main", 128'(exp_q.size()), 128'd0);
    check("drain_noseq", 128'(exp2_q.size()), 128'd0);
  endtask

  task automatic reset_cycle();
    rst_n = 1'b0;
    m_seen = 1'b0; m_last_seq = '0; m_count = '0;
    @(negedge clk);
    check("reset_ready", 128'(rdy), 128'd0);
    check("reset_outputs", 128'(act1()), 128'd0);
    check("reset_noseq_outputs", 128'(act2()), 128'd0);
    #2 rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_reset", 128'({rdy, n_rdy}), 128'd3);
    mon_en = 1'b1;
  endtask

  initial begin
    reset_cycle();

    mk(32'd5, 32'h0102_0003, 3); send_frame(frame.size());
    frame.delete();
    for (int i = 0; i < 6; i++) frame.push_back(32'h1234_5678 + 32'(i));
    send_frame(frame.size());
    mk(32'd6, 32'h0011_0022, 2); send_frame(frame.size());
    mk(32'd7, 32'h0201_0001, 1); send_frame(frame.size());
    mk(32'd8, 32'h0202_0002, 2); send_frame(frame.size());
    mk(32'd10, 32'h0203_0003, 3); send_frame(frame.size());
    mk(32'd11, 32'h0900_0000, 2); send_frame(frame.size());
    frame.delete();
    frame.push_back(MAGIC); frame.push_back(32'd12); frame.push_back(32'h0200_0000);
    send_frame(frame.size());
    mk(32'd13, 32'h0300_0001, 2); send_frame(frame.size());
    mk(32'd14, 32'h0100_0004, 6); send_frame(frame.size());
    drain();

    for (int i = 0; i < 150; i++) gen_random();
    drain();

    // Abort mid-payload: only the two delivered words may appear, never a Cfg_last.
    mk(m_last_seq + 32'd1, 32'h0200_0005, 4);
    send_frame(6);
    #2;
    check("pre_reset_queue", 128'(exp_q.size() + exp2_q.size()), 128'd0);
    mon_en = 1'b0;
    reset_cycle();
    mk(32'd100, 32'h0100_0000, 3); send_frame(frame.size());
    for (int i = 0; i < 20; i++) gen_random();
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
